// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if -- bridge-side register bus of the interrupt controller.
//   we    : write strobe (one cycle per write)
//   addr  : register select (0 MASK, 1 MODE, 2 PEND, 3 CTRL)
//   wd    : write data
//   rd    : read data, combinational from addr
// master = bridge / CPU side, slave = irq_ctrl.
// ---------------------------------------------------------------------------
interface irq_ctrl_if;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wd;
   logic [31:0] rd;

   modport master (output we, addr, wd, input rd);
   modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- programmable interrupt controller between peripheral IRQ lines
// and the CPU HWInt input.
//   clk     : system clock, all state on the rising edge
//   rst     : asynchronous, active-low reset
//   irq_in  : raw device requests, asynchronous to clk
//   bus     : register bus (we/addr/wd in, rd out)
//   HWInt   : registered one-hot request to the CPU
//   int_req : registered OR of HWInt
// Requests are synchronised, latched as edge/level pending bits, masked and
// arbitrated lowest-index-first. One request at a time is presented and walked
// through IDLE -> ASSERT -(ACK)-> SERVICE -(EOI)-> IDLE.
// ---------------------------------------------------------------------------
module irq_ctrl #(
   parameter int NUM_IRQ     = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   irq_ctrl_if.slave          bus,
   output logic [NUM_IRQ-1:0] HWInt,
   output logic               int_req
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   // Synchroniser: index 0 is the newest stage.
   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
   logic [NUM_IRQ-1:0] s, s_d, edge_set;

   logic [NUM_IRQ-1:0] mask, mode, pend, pend_n, active;
   logic [NUM_IRQ-1:0] w1c, ack_clr, hw_n;
   logic [1:0]         state, state_n;
   logic [2:0]         id, id_n, win_id;
   logic               ack, eoi, ack_fire;

   assign s        = sync_q[SYNC_STAGES-1];
   assign edge_set = s & ~s_d;
   assign active   = pend & mask;

   assign ack      = bus.we && (bus.addr == 2'd3) && bus.wd[0];
   assign eoi      = bus.we && (bus.addr == 2'd3) && bus.wd[1];
   assign ack_fire = ack && (state == ST_ASSERT);

   // In ASSERT, HWInt already holds onehot(id), so it doubles as the id mask
   // for both the ACK clear and the withdrawal test.
   assign ack_clr = ack_fire ? HWInt : '0;
   assign w1c     = (bus.we && (bus.addr == 2'd2)) ? bus.wd[NUM_IRQ-1:0] : '0;

   // Edge bits: set wins over any same-cycle clear. Level bits track s, which
   // also discards a stored edge bit as soon as a line switches to level.
   assign pend_n = (mode & (edge_set | (pend & ~(w1c | ack_clr)))) | (~mode & s);

   // Lowest index wins: scan downwards so the last hit is the lowest.
   always_comb begin
      win_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (active[i]) win_id = 3'(i);
   end

   always_comb begin
      state_n = state;
      id_n    = id;
      hw_n    = HWInt;
      case (state)
         ST_IDLE: begin
            if (|active) begin
               state_n = ST_ASSERT;
               id_n    = win_id;
               hw_n    = NUM_IRQ'(1) << win_id;
            end
         end
         ST_ASSERT: begin
            // ACK beats a same-cycle withdrawal; no preemption while asserting.
            if (ack) begin
               state_n = ST_SERVICE;
               hw_n    = '0;
            end else if (~|(active & HWInt)) begin
               state_n = ST_IDLE;
               id_n    = '0;
               hw_n    = '0;
            end
         end
         ST_SERVICE: begin
            if (eoi) begin
               state_n = ST_IDLE;
               id_n    = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            id_n    = '0;
            hw_n    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         s_d     <= '0;
         mask    <= '0;
         mode    <= '0;
         pend    <= '0;
         state   <= ST_IDLE;
         id      <= '0;
         HWInt   <= '0;
         int_req <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_in};
         s_d     <= s;
         pend    <= pend_n;
         state   <= state_n;
         id      <= id_n;
         HWInt   <= hw_n;
         int_req <= |hw_n;
         if (bus.we && (bus.addr == 2'd0)) mask <= bus.wd[NUM_IRQ-1:0];
         if (bus.we && (bus.addr == 2'd1)) mode <= bus.wd[NUM_IRQ-1:0];
      end
   end

   always_comb begin
      bus.rd = '0;
      case (bus.addr)
         2'd0:    bus.rd = 32'(mask);
         2'd1:    bus.rd = 32'(mode);
         2'd2:    bus.rd = 32'(pend);
         default: bus.rd = {state == ST_SERVICE, state == ST_ASSERT, 27'd0, id};
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl -- directed walk through the controller's main scenarios with
// literal expectations, then randomized irq/register traffic. A cycle model
// built from the register-map and handshake rules runs alongside and is
// compared against HWInt, int_req and rd on every falling edge.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;
   localparam int N    = 6;
   localparam int SYNC = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] irq_in = '0;
   logic [N-1:0] HWInt;
   logic         int_req;
   bit           chk_en = 1'b0;

   int total = 0;
   int bad   = 0;

   irq_ctrl_if bus();

   irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(SYNC)) dut (
      .clk     (clk),
      .rst     (rst),
      .irq_in  (irq_in),
      .bus     (bus),
      .HWInt   (HWInt),
      .int_req (int_req)
   );

   always #10 clk = ~clk;

   // ---------------- reference model ----------------
   // m_state: 0 idle, 1 asserting, 2 in service
   bit [N-1:0] m_mask, m_mode, m_pend, m_hw;
   bit [N-1:0] m_hist[$];   // irq_in samples, newest first
   int         m_state, m_id;
   bit         m_int;

   function automatic int lowest(bit [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] m_rd(logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_mask);
         2'd1:    return 32'(m_mode);
         2'd2:    return 32'(m_pend);
         default: return {m_state == 2, m_state == 1, 27'd0, 3'(m_id)};
      endcase
   endfunction

   task automatic model_step();
      bit [N-1:0] s, sd, act, np;
      bit         ack, eoi;
      if (!rst) begin
         m_mask = '0; m_mode = '0; m_pend = '0; m_hw = '0;
         m_state = 0; m_id = 0; m_int = 1'b0;
         m_hist = {};
         for (int i = 0; i <= SYNC; i++) m_hist.push_back('0);
         return;
      end
      s   = m_hist[SYNC-1];
      sd  = m_hist[SYNC];
      ack = bus.we && bus.addr == 2'd3 && bus.wd[0];
      eoi = bus.we && bus.addr == 2'd3 && bus.wd[1];
      act = m_pend & m_mask;
      np  = m_pend;
      for (int i = 0; i < N; i++) begin
         if (!m_mode[i]) np[i] = s[i];
         else begin
            if (bus.we && bus.addr == 2'd2 && bus.wd[i]) np[i] = 1'b0;
            if (ack && m_state == 1 && m_id == i) np[i] = 1'b0;
            if (s[i] && !sd[i]) np[i] = 1'b1;
         end
      end
      if (m_state == 0) begin
         if (act != 0) begin
            m_id = lowest(act); m_hw = '0; m_hw[m_id] = 1'b1; m_state = 1;
         end
      end else if (m_state == 1) begin
         if (ack) begin m_hw = '0; m_state = 2; end
         else if (!act[m_id]) begin m_hw = '0; m_state = 0; m_id = 0; end
      end else if (eoi) begin
         m_state = 0; m_id = 0;
      end
      m_pend = np;
      m_int  = (m_hw != 0);
      if (bus.we && bus.addr == 2'd0) m_mask = bus.wd[N-1:0];
      if (bus.we && bus.addr == 2'd1) m_mode = bus.wd[N-1:0];
      m_hist.push_front(irq_in);
      void'(m_hist.pop_back());
   endtask

   initial begin
      for (int i = 0; i <= SYNC; i++) m_hist.push_back('0);
      forever begin
         @(posedge clk or negedge rst);
         model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && chk_en) begin
         check("model_hwint", 32'(HWInt), 32'(m_hw));
         check("model_int_req", 32'(int_req), 32'(m_int));
         check("model_rd", bus.rd, m_rd(bus.addr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      bus.we = 1'b1; bus.addr = a; bus.wd = d;
      tick();
      bus.we = 1'b0;
   endtask

   task automatic rdchk(string name, logic [1:0] a, logic [31:0] exp);
      bus.addr = a; #1;
      check(name, bus.rd, exp);
   endtask

   task automatic pulse(logic [N-1:0] v);
      irq_in = v; tick(); irq_in = '0;
   endtask

   initial begin
      bus.we = 1'b0; bus.addr = 2'd0; bus.wd = '0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk_en = 1'b1;

      // reset state
      for (int a = 0; a < 4; a++) rdchk("reset_rd", 2'(a), 32'h0);
      check("reset_hwint", 32'(HWInt), 32'h0);
      check("reset_int_req", 32'(int_req), 32'h0);

      // masked edge request latches but is not presented
      wr(2'd1, 32'h3F);
      pulse(6'b001000);
      repeat (3) tick();
      rdchk("masked_pend", 2'd2, 32'h08);
      check("masked_hwint", 32'(HWInt), 32'h0);
      wr(2'd2, 32'h08);
      rdchk("w1c_pend", 2'd2, 32'h0);

      // latency: sample edge k, HWInt after k+3
      wr(2'd0, 32'h3F);
      pulse(6'b000100);
      tick(); tick();
      check("lat_k2_hwint", 32'(HWInt), 32'h0);
      rdchk("lat_k2_pend", 2'd2, 32'h04);
      tick();
      check("lat_k3_hwint", 32'(HWInt), 32'h04);
      check("lat_k3_model", 32'(m_hw), 32'h04);
      check("lat_int_req", 32'(int_req), 32'h1);
      rdchk("assert_ctrl", 2'd3, 32'h40000002);
      wr(2'd3, 32'h1);
      check("ack_hwint", 32'(HWInt), 32'h0);
      rdchk("ack_pend", 2'd2, 32'h0);
      rdchk("service_ctrl", 2'd3, 32'h80000002);
      wr(2'd3, 32'h2);
      rdchk("eoi_ctrl", 2'd3, 32'h0);

      // priority and back-to-back after EOI
      pulse(6'b010010);
      repeat (3) tick();
      check("prio_hwint", 32'(HWInt), 32'h02);
      wr(2'd3, 32'h1);
      wr(2'd3, 32'h2);
      check("b2b_eoi_edge", 32'(HWInt), 32'h0);
      tick();
      check("b2b_hwint", 32'(HWInt), 32'h10);
      rdchk("b2b_ctrl", 2'd3, 32'h40000004);
      wr(2'd3, 32'h3);
      rdchk("ack_eoi_both", 2'd3, 32'h80000004);
      wr(2'd3, 32'h2);

      // level-mode withdrawal
      wr(2'd1, 32'h3E);
      irq_in = 6'b000001;
      repeat (4) tick();
      check("level_hwint", 32'(HWInt), 32'h01);
      rdchk("level_ctrl", 2'd3, 32'h40000000);
      irq_in = '0;
      repeat (3) tick();
      check("level_hold", 32'(HWInt), 32'h01);
      tick();
      check("withdraw_hwint", 32'(HWInt), 32'h0);
      rdchk("withdraw_ctrl", 2'd3, 32'h0);
      wr(2'd1, 32'h3F);

      // masking in ASSERT, set-wins-over-W1C
      pulse(6'b100000);
      repeat (3) tick();
      check("id5_hwint", 32'(HWInt), 32'h20);
      wr(2'd0, 32'h1F);
      check("mask_edge_hwint", 32'(HWInt), 32'h20);
      tick();
      check("mask_drop_hwint", 32'(HWInt), 32'h0);
      rdchk("mask_drop_pend", 2'd2, 32'h20);
      wr(2'd2, 32'h20);
      rdchk("mask_w1c", 2'd2, 32'h0);
      pulse(6'b100000);
      tick();
      wr(2'd2, 32'h20);
      rdchk("set_wins", 2'd2, 32'h20);
      wr(2'd2, 32'h20);
      wr(2'd0, 32'h3F);

      // asynchronous reset in SERVICE
      pulse(6'b000010);
      repeat (3) tick();
      wr(2'd3, 32'h1);
      pulse(6'b001000);
      repeat (3) tick();
      rdchk("pre_rst_pend", 2'd2, 32'h08);
      rdchk("pre_rst_ctrl", 2'd3, 32'h80000001);
      rdchk("pre_rst_mask", 2'd0, 32'h3F);
      rst = 1'b0; #1;
      check("arst_hwint", 32'(HWInt), 32'h0);
      check("arst_int_req", 32'(int_req), 32'h0);
      rdchk("arst_mask", 2'd0, 32'h0);
      rdchk("arst_pend", 2'd2, 32'h0);
      rdchk("arst_ctrl", 2'd3, 32'h0);
      @(posedge clk); #1 rst = 1'b1;

      // randomized traffic against the model
      repeat (3000) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
         bus.we   = ($urandom_range(0, 3) == 0);
         bus.addr = 2'($urandom_range(0, 3));
         bus.wd   = (bus.addr == 2'd3) ? 32'($urandom_range(0, 3)) : $urandom;
         tick();
      end
      bus.we = 1'b0; irq_in = '0;
      repeat (8) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Programmable interrupt controller placed between the peripheral IRQ lines (timer, input/output devices) and the CPU's HWInt input. It synchronises raw requests, latches them as edge- or level-triggered pending bits, masks them, and arbitrates by fixed priority. It presents one request at a time to the CPU and sequences it through an ACK/EOI handshake. Its register file sits as a bridge device: 2-bit address, 32-bit data, single write enable.

Parameters:
NUM_IRQ, 6, number of request inputs; equals HWInt width; max 8
SYNC_STAGES, 2, flip-flop depth of the input synchroniser; min 2

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
irq_in  input  NUM_IRQ  raw device requests, asynchronous to clk
we  input  1  register write strobe from bridge
addr  input  2  register select
wd  input  32  write data
rd  output  32  read data, combinational from addr
HWInt  output  NUM_IRQ  one-hot registered request to CPU
int_req  output  1  OR of HWInt

Behaviour:
- Reset (rst=0, asynchronous): MASK=0, MODE=0, PEND=0, sync/edge flops=0, id=0, FSM=IDLE, HWInt=0, int_req=0. rd reads 0 at every address after reset.
- Register map:
  - addr0 MASK, rw, bits[NUM_IRQ-1:0]; 1 = enabled.
  - addr1 MODE, rw; 1 = edge, 0 = level.
  - addr2 PEND, read; a write clears edge-mode bits where wd=1 (W1C). Level-mode bits are not writable.
  - addr3 CTRL. Read: bit31 = in-service, bit30 = asserting, bits[2:0] = id. Write: wd[0] = ACK, wd[1] = EOI.
  - Unused rd bits read 0.
- Synchroniser: SYNC_STAGES flops per line. s = last stage, s_d = s delayed 1 cycle. edge = s & ~s_d.
- PEND update, per bit:
  - Edge mode: set on edge, cleared by W1C or by ACK of that id. Set wins over a simultaneous clear.
  - Level mode: PEND = s (registered).
  - Changing MODE to level discards the stored edge bit.
- active = PEND & MASK. Priority: lowest index wins. id = index of the lowest set bit.
- FSM states:
  - IDLE: if active != 0, latch id, go to ASSERT. HWInt = onehot(id) in the same registered update.
  - ASSERT: HWInt held.
    - ACK write: clear PEND[id] if edge mode, HWInt -> 0, go to SERVICE.
    - Else if active[id] == 0 (source withdrew, W1C, or masked): HWInt -> 0, go to IDLE (spurious withdrawal).
    - ACK takes precedence over a same-cycle withdrawal.
    - A higher-priority request arriving in ASSERT does not preempt; id is fixed until ACK or withdrawal.
  - SERVICE: HWInt = 0. EOI write -> IDLE. Other requests keep accumulating in PEND. No nesting.
- Ignored writes: ACK in IDLE or SERVICE; EOI in IDLE or ASSERT. wd[1:0] = 11 in ASSERT acts as ACK only.
- Latency, with SYNC_STAGES=2, FSM in IDLE, line enabled in edge mode:
  - irq_in sampled high at edge k -> PEND bit set at edge k+2 -> HWInt high after edge k+3.
  - Minimum 4 cycles request-to-HWInt.
  - HWInt falls on the edge that registers the ACK write.
- Back-to-back: after EOI, FSM returns to IDLE. A pending request re-asserts HWInt 1 cycle after the EOI edge.
- int_req = |HWInt, registered.

Test Plan:
- Reset, then read all 4 addresses -> each returns 0. HWInt=0. Pulse irq_in[3] with MASK=0 -> PEND[3]=1, HWInt stays 0.
- MASK=0x3F, MODE=0x3F; 1-cycle pulse on irq_in[2] at edge k -> HWInt=6'b000100 after edge k+3. Read CTRL = 0x40000002. ACK -> HWInt=0, PEND[2]=0, CTRL=0x80000002. EOI -> CTRL=0.
- Simultaneous pulses on irq_in[4] and irq_in[1] -> HWInt=000010. Then ACK, EOI -> irq 4 asserts HWInt=010000 one cycle after the EOI edge.
- Level mode, irq_in[0] high then dropped before ACK -> HWInt returns to 0 (spurious withdrawal), FSM IDLE, CTRL=0.
- In ASSERT for id 5, write MASK=0x1F -> HWInt=0 next cycle. Same edge as an irq_in[5] edge-detect, W1C PEND=0x20 -> PEND[5] stays 1.
- Drive rst low mid-SERVICE -> HWInt, PEND, MASK, CTRL all 0 immediately, without waiting for a clk edge.
